// File: rtl/spi_frame_decoder.sv
// SPI-clock-domain frame decoder: command byte (R/nW + start address) followed by
// data bytes, producing single-cycle write strobes and read-prefetch requests.
module spi_frame_decoder #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned AUTO_INC  = 1
) (
    input  logic       i_Rst_L,
    input  logic       w_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_Cmd_Valid,
    output logic       o_Rd_nWr,
    output logic [6:0] o_Addr,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Data,
    output logic       o_Rd_En,
    output logic [7:0] o_Byte_Cnt,
    output logic       o_Frame_Err,
    output logic       o_Busy
);

    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'((AUTO_INC != 0) ? 1 : 0);
    localparam logic [BYTE_W-1:0] BURST_LIM = BYTE_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        OVFL = 2'd3
    } state_t;

    state_t                 state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0]      shift_q;
    logic [ADDR_W-1:0]      next_addr;
    logic [BYTE_W-1:0]      byte_c;
    logic [ADDR_W-1:0]      addr_inc_c;

    // Byte as it stands once the current MOSI bit is shifted in.
    assign byte_c     = {shift_q[BYTE_W-2:0], i_SPI_MOSI};
    assign addr_inc_c = next_addr + ADDR_STEP;

    // Frame FSM; all outputs registered, strobes default low every edge.
    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            next_addr   <= '0;
            o_Cmd_Valid <= 1'b0;
            o_Rd_nWr    <= 1'b0;
            o_Addr      <= '0;
            o_Wr_En     <= 1'b0;
            o_Wr_Data   <= '0;
            o_Rd_En     <= 1'b0;
            o_Byte_Cnt  <= '0;
            o_Frame_Err <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            o_Cmd_Valid <= 1'b0;
            o_Wr_En     <= 1'b0;
            o_Rd_En     <= 1'b0;

            if (state == IDLE) begin
                if (!i_SPI_CS_n) begin
                    shift_q     <= byte_c;
                    bit_cnt     <= BIT_CNT_W'(1);
                    o_Frame_Err <= 1'b0;
                    o_Byte_Cnt  <= '0;
                    o_Busy      <= 1'b1;
                    state       <= CMD;
                end
            end else if (i_SPI_CS_n) begin
                // CS deassert wins over any byte completion on this edge.
                state   <= IDLE;
                o_Busy  <= 1'b0;
                bit_cnt <= '0;
                if (bit_cnt != '0) begin
                    o_Frame_Err <= 1'b1;
                end
            end else begin
                shift_q <= byte_c;
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                if (bit_cnt == BIT_CNT_W'(7)) begin
                    case (state)
                        CMD: begin
                            o_Rd_nWr    <= byte_c[7];
                            o_Addr      <= byte_c[ADDR_W-1:0];
                            next_addr   <= byte_c[ADDR_W-1:0];
                            o_Cmd_Valid <= 1'b1;
                            o_Rd_En     <= byte_c[7];
                            state       <= DATA;
                        end
                        DATA: begin
                            if (o_Byte_Cnt == BURST_LIM) begin
                                o_Frame_Err <= 1'b1;
                                state       <= OVFL;
                            end else if (o_Rd_nWr) begin
                                // Prefetch the byte that will be shifted out next.
                                next_addr  <= addr_inc_c;
                                o_Addr     <= addr_inc_c;
                                o_Rd_En    <= 1'b1;
                                o_Byte_Cnt <= o_Byte_Cnt + BYTE_W'(1);
                            end else begin
                                o_Wr_En    <= 1'b1;
                                o_Wr_Data  <= byte_c;
                                o_Addr     <= next_addr;
                                next_addr  <= addr_inc_c;
                                o_Byte_Cnt <= o_Byte_Cnt + BYTE_W'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder (default MAX_BURST=16, AUTO_INC=1).
module tb_spi_frame_decoder;

    logic       clk;
    logic       rst_l;
    logic       cs_n;
    logic       mosi;
    logic       cmd_valid;
    logic       rd_nwr;
    logic [6:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] byte_cnt;
    logic       frame_err;
    logic       busy;

    int errors;
    int checks;

    // Strobe logs captured by the monitor.
    int         wr_n;
    int         rd_n;
    int         cmd_n;
    logic [6:0] wr_addr [0:31];
    logic [7:0] wr_dat  [0:31];
    logic [6:0] rd_addr [0:31];

    spi_frame_decoder dut (
        .i_Rst_L     (rst_l),
        .w_SPI_Clk   (clk),
        .i_SPI_CS_n  (cs_n),
        .i_SPI_MOSI  (mosi),
        .o_Cmd_Valid (cmd_valid),
        .o_Rd_nWr    (rd_nwr),
        .o_Addr      (addr),
        .o_Wr_En     (wr_en),
        .o_Wr_Data   (wr_data),
        .o_Rd_En     (rd_en),
        .o_Byte_Cnt  (byte_cnt),
        .o_Frame_Err (frame_err),
        .o_Busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe, sampled half a period after the active edge.
    always @(negedge clk) begin
        if (wr_en && wr_n < 32) begin
            wr_addr[wr_n] = addr;
            wr_dat[wr_n]  = wr_data;
        end
        if (wr_en) wr_n = wr_n + 1;
        if (rd_en && rd_n < 32) rd_addr[rd_n] = addr;
        if (rd_en) rd_n = rd_n + 1;
        if (cmd_valid) cmd_n = cmd_n + 1;
    end

    task automatic clear_logs();
        wr_n  = 0;
        rd_n  = 0;
        cmd_n = 0;
    endtask

    // Drive one SPI edge, then settle just after it.
    task automatic drive(input logic c, input logic d);
        @(negedge clk);
        cs_n = c;
        mosi = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) drive(1'b0, b[i]);
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_valid, rd_nwr, addr, wr_en, wr_data, rd_en, byte_cnt, frame_err, busy} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {cmd_valid, rd_nwr, addr, wr_en, wr_data, rd_en, byte_cnt, frame_err, busy});
        end
        @(negedge clk);
        rst_l = 1'b1;
        drive(1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_write_burst();
        logic [7:0] cmd;
        cmd = 8'h05;
        clear_logs();
        for (int i = 7; i >= 1; i--) drive(1'b0, cmd[i]);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_cmd_early: got %b want 0", cmd_valid);
        end
        drive(1'b0, cmd[0]);
        checks++;
        if ({cmd_valid, rd_nwr, addr, busy, rd_en} !== {1'b1, 1'b0, 7'h05, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wr_cmd_decode: got v=%b r=%b a=%h b=%b rd=%b want 1 0 05 1 0",
                     cmd_valid, rd_nwr, addr, busy, rd_en);
        end
        send_byte(8'hA1);
        checks++;
        if ({wr_en, addr, wr_data} !== {1'b1, 7'h05, 8'hA1}) begin
            errors++;
            $display("FAIL wr_first_strobe: got en=%b a=%h d=%h want 1 05 a1", wr_en, addr, wr_data);
        end
        send_byte(8'hB2);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (wr_n !== 2 || rd_n !== 0 || cmd_n !== 1) begin
            errors++;
            $display("FAIL wr_strobe_counts: got wr=%0d rd=%0d cmd=%0d want 2 0 1", wr_n, rd_n, cmd_n);
        end
        checks++;
        if ({wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]} !== {7'h05, 8'hA1, 7'h06, 8'hB2}) begin
            errors++;
            $display("FAIL wr_log: got %h/%h %h/%h want 05/a1 06/b2",
                     wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]);
        end
        checks++;
        if ({byte_cnt, frame_err, busy, addr, wr_data} !== {8'd2, 1'b0, 1'b0, 7'h06, 8'hB2}) begin
            errors++;
            $display("FAIL wr_end_state: got cnt=%0d err=%b busy=%b a=%h d=%h want 2 0 0 06 b2",
                     byte_cnt, frame_err, busy, addr, wr_data);
        end
    endtask

    task automatic test_read_burst();
        clear_logs();
        send_byte(8'h90);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h5A);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (rd_n !== 4 || wr_n !== 0 || cmd_n !== 1) begin
            errors++;
            $display("FAIL rd_strobe_counts: got rd=%0d wr=%0d cmd=%0d want 4 0 1", rd_n, wr_n, cmd_n);
        end
        checks++;
        if ({rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]} !== {7'h10, 7'h11, 7'h12, 7'h13}) begin
            errors++;
            $display("FAIL rd_log: got %h %h %h %h want 10 11 12 13",
                     rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]);
        end
        checks++;
        if ({byte_cnt, rd_nwr, frame_err} !== {8'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rd_end_state: got cnt=%0d rnw=%b err=%b want 3 1 0", byte_cnt, rd_nwr, frame_err);
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        send_byte(8'h7F);
        send_byte(8'h11);
        send_byte(8'h22);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (wr_n !== 2 || {wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]} !== {7'h7F, 8'h11, 7'h00, 8'h22}) begin
            errors++;
            $display("FAIL wrap_log: got n=%0d %h/%h %h/%h want 2 7f/11 00/22",
                     wr_n, wr_addr[0], wr_dat[0], wr_addr[1], wr_dat[1]);
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        send_byte(8'h00);
        for (int k = 0; k < 16; k++) send_byte(8'(k + 1));
        checks++;
        if ({byte_cnt, frame_err} !== {8'd16, 1'b0}) begin
            errors++;
            $display("FAIL ovf_at_limit: got cnt=%0d err=%b want 16 0", byte_cnt, frame_err);
        end
        send_byte(8'hEE);
        checks++;
        if ({wr_en, frame_err, busy, byte_cnt} !== {1'b0, 1'b1, 1'b1, 8'd16}) begin
            errors++;
            $display("FAIL ovf_extra_byte: got en=%b err=%b busy=%b cnt=%0d want 0 1 1 16",
                     wr_en, frame_err, busy, byte_cnt);
        end
        send_byte(8'h77);
        drive(1'b1, 1'b0);
        checks++;
        if (wr_n !== 16 || wr_addr[0] !== 7'h00 || wr_addr[15] !== 7'h0F || wr_dat[15] !== 8'h10) begin
            errors++;
            $display("FAIL ovf_log: got n=%0d a0=%h a15=%h d15=%h want 16 00 0f 10",
                     wr_n, wr_addr[0], wr_addr[15], wr_dat[15]);
        end
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b want 1", frame_err);
        end
        drive(1'b0, 1'b0);
        checks++;
        if ({frame_err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_clear_next: got err=%b busy=%b want 0 1", frame_err, busy);
        end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
    endtask

    task automatic test_partial();
        logic [7:0] tail;
        tail = 8'hB0;
        clear_logs();
        send_byte(8'h03);
        for (int i = 7; i >= 3; i--) drive(1'b0, tail[i]);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (cmd_n !== 1 || wr_n !== 0) begin
            errors++;
            $display("FAIL partial_strobes: got cmd=%0d wr=%0d want 1 0", cmd_n, wr_n);
        end
        checks++;
        if ({frame_err, busy, byte_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL partial_state: got err=%b busy=%b cnt=%0d want 1 0 0", frame_err, busy, byte_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'hFF;
        clear_logs();
        send_byte(8'h40);
        for (int i = 7; i >= 4; i--) drive(1'b0, d[i]);
        #2;
        rst_l = 1'b0;
        cs_n  = 1'b1;
        #1;
        checks++;
        if ({cmd_valid, rd_nwr, addr, wr_en, wr_data, rd_en, byte_cnt, frame_err, busy} !== 29'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h want 0",
                     {cmd_valid, rd_nwr, addr, wr_en, wr_data, rd_en, byte_cnt, frame_err, busy});
        end
        @(negedge clk);
        rst_l = 1'b1;
        drive(1'b1, 1'b0);
        send_byte(8'h22);
        send_byte(8'h5A);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (wr_n !== 1 || {wr_addr[0], wr_dat[0]} !== {7'h22, 8'h5A} || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_new_frame: got n=%0d %h/%h err=%b want 1 22/5a 0",
                     wr_n, wr_addr[0], wr_dat[0], frame_err);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_logs();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_overflow();
        test_partial();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_frame_decoder.md
Name: spi_frame_decoder

Overview:
- SPI-clock-domain frame decoder that sits directly downstream of the MOSI deserialiser in the SPI slave path.
- Assembles MOSI bits into a command byte followed by data bytes:
  - command byte: bit7 = R/nW, bits6:0 = start address.
  - subsequent bytes are data, with auto-incrementing address.
- Issues single-cycle register-bank write strobes and read-prefetch requests.
- The read requests let the TX byte be staged before the next byte is shifted out on MISO.

Parameters:
- MAX_BURST, 16: maximum data bytes per frame after the command byte. Legal range 1..255.
- AUTO_INC, 1: 1 = address increments after each data byte; 0 = address stays fixed (FIFO-style register).

Ports:
- i_Rst_L  input  1  reset, asynchronous, active-low.
- w_SPI_Clk  input  1  clock; mode-adjusted SPI sampling clock; all logic on rising edge.
- i_SPI_CS_n  input  1  chip select, active-low, sampled synchronously.
- i_SPI_MOSI  input  1  serial data, MSb first.
- o_Cmd_Valid  output  1  one-cycle pulse; command byte decoded.
- o_Rd_nWr  output  1  frame direction latched from command bit7.
- o_Addr  output  7  address for the current strobe.
- o_Wr_En  output  1  one-cycle write strobe.
- o_Wr_Data  output  8  write data, valid with o_Wr_En.
- o_Rd_En  output  1  one-cycle read-prefetch request for o_Addr.
- o_Byte_Cnt  output  8  data bytes accepted in the current frame.
- o_Frame_Err  output  1  sticky frame error flag.
- o_Busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async on i_Rst_L low): state IDLE, bit counter 0, shift register 0, internal next-address 0. All outputs 0.
- Frame boundaries:
  - i_SPI_CS_n is sampled on w_SPI_Clk only.
  - Frame termination takes effect on the first edge that samples CS_n high.
  - The system master supplies at least one w_SPI_Clk edge with CS_n high between frames.
- States: IDLE, CMD, DATA, OVFL.
- IDLE:
  - Edge with CS_n low: shift in MOSI, bit count = 1, clear o_Frame_Err, o_Byte_Cnt = 0, o_Busy = 1, go to CMD.
  - Edge with CS_n high: stay in IDLE.
- Any non-IDLE state, edge with CS_n low:
  - Shift register <= {shift[6:0], MOSI}; bit count increments (3-bit, wraps 7 -> 0).
  - The edge sampling bit count 7 completes byte B = {shift[6:0], MOSI}.
- CMD on byte complete:
  - o_Rd_nWr = B[7]; o_Addr = B[6:0]; next-address = B[6:0].
  - Pulse o_Cmd_Valid; go to DATA.
  - If B[7] = 1, pulse o_Rd_En in the same cycle (prefetch first read byte).
- DATA on byte complete, write frame:
  - Pulse o_Wr_En; o_Wr_Data = B; o_Addr = next-address.
  - next-address += AUTO_INC (7-bit, 0x7F wraps to 0x00).
  - o_Byte_Cnt += 1.
- DATA on byte complete, read frame:
  - MOSI byte is ignored.
  - next-address += AUTO_INC; o_Addr = incremented address; pulse o_Rd_En.
  - o_Byte_Cnt += 1.
- Burst limit:
  - A byte completing while o_Byte_Cnt == MAX_BURST produces no strobe.
  - It sets o_Frame_Err and moves to OVFL.
  - OVFL ignores all bits until CS_n is sampled high.
- Strobe timing:
  - Strobes are registered: high for exactly one w_SPI_Clk period, starting at the edge that samples the 8th bit.
  - A strobe never repeats on consecutive edges.
- CS_n sampled high in any non-IDLE state:
  - Go to IDLE; o_Busy = 0; strobes 0.
  - If bit count != 0 (partial byte), set o_Frame_Err.
  - o_Addr, o_Rd_nWr, o_Wr_Data and o_Byte_Cnt hold their last values.
- o_Frame_Err: sticky until the first CS-low edge of the next frame.
- Simultaneous events:
  - CS_n high takes priority over byte completion; a byte is never completed on an edge where CS_n is high.
- Reset mid-frame: immediate return to the reset state. The frame is abandoned with no strobe, and the next frame starts cleanly from a CMD.
- Latency: 8 edges from CS low to o_Cmd_Valid. Each subsequent strobe follows 8 edges after the previous one.

Test Plan:
- Write burst: CS low, send 0x05, 0xA1, 0xB2, CS high -> o_Cmd_Valid, o_Rd_nWr = 0; o_Wr_En twice with (addr 0x05, data 0xA1) then (0x06, 0xB2); o_Byte_Cnt = 2; o_Frame_Err = 0.
- Read burst: send 0x90 then three dummy bytes -> o_Rd_En at addr 0x10, then 0x11, 0x12, 0x13; no o_Wr_En; o_Byte_Cnt = 3.
- Wrap: write frame with command 0x7F and 2 data bytes -> writes at 0x7F then 0x00.
- Overflow: MAX_BURST = 2, command 0x00 plus 3 data bytes -> two o_Wr_En (addr 0x00, 0x01); third byte gives no strobe; o_Frame_Err = 1; next frame clears the flag on its first edge.
- Partial byte: send 0x03, then 5 bits, then CS high -> one o_Cmd_Valid, no o_Wr_En, o_Frame_Err = 1, o_Busy = 0.
- Reset mid-frame: assert i_Rst_L low after 4 bits of a data byte -> all outputs 0 immediately; after release, a new frame 0x22, 0x5A yields a write at (0x22, 0x5A).
